count_uart_tx: RTL and testbench
================================

Name: count_uart_tx

Overview:
Downstream consumer of the 8-bit counter stage. Accepts a byte over a valid/ready handshake and serialises it on a single UART TX pin as 8N1. It sends either the raw byte or its two-character uppercase ASCII hex form followed by CR LF, so an external terminal can watch the count. Sits between the counter output bus and a dedicated output pin of the top-level tile.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
HEX_MODE, 1, 1 = send 4 frames (hex hi, hex lo, 0x0D, 0x0A); 0 = send 1 raw frame.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
data_in  input  8  byte to transmit (counter value)
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  block can accept a byte this cycle
tx  output  1  UART serial line, idle high
busy  output  1  high while any frame is in progress

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on rst_n. All state is updated on the posedge clk; rst_n low clears all state immediately.
- Reset values: tx=1, busy=0, data_ready=1, FSM=IDLE, baud counter=0, bit index=0, char index=0, holding register=0x00.
- A byte is accepted when data_valid && data_ready && ena are all high at a clk edge. data_in is latched into the holding register.
- After acceptance, data_ready=0 and busy=1 from the next cycle until the FSM returns to IDLE.
- data_valid while data_ready=0 is ignored. No queuing; the upstream stage must hold or drop the byte.
- FSM states:
  - IDLE: tx=1, data_ready=1, busy=0. On acceptance, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index runs 0..7, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the char index is below the last char, increment it and go to START; otherwise go to IDLE.
- tx is registered. The first start-bit cycle is the cycle after acceptance.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
  - HEX_MODE=0: one frame per byte.
  - HEX_MODE=1: four back-to-back frames with no idle gap between them.
- Minimum gap between transactions: one IDLE cycle (tx=1, data_ready=1) after the final stop bit. The earliest next start bit is therefore 10*CLKS_PER_BIT+1 cycles (raw) or 40*CLKS_PER_BIT+1 cycles (hex) after the previous start.
- Hex mapping: nibble 0..9 -> 0x30..0x39; nibble A..F -> 0x41..0x46 (uppercase). The high nibble is sent first.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- ena low: the FSM, baud counter, bit and char indices all hold. tx holds its current level. No acceptance occurs (data_ready stays at its current value but the handshake is qualified by ena). The frame stretches by exactly the number of cycles ena is low.
- rst_n asserted mid-frame: tx goes to 1 immediately (asynchronously), the holding byte and remaining chars are discarded, and the block returns to IDLE on release. No partial frame is resumed.
- Acceptance in the same cycle as FSM completion: not possible, because data_ready is low during STOP. This is by design.

Test Plan:
1. HEX_MODE=0, CLKS_PER_BIT=4. Send 0xA5.
   -> tx: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
   -> busy high for 40 cycles; data_ready returns high on cycle 41.
2. HEX_MODE=1, CLKS_PER_BIT=4. Send 0x3C.
   -> decoded frames are 0x33, 0x43, 0x0D, 0x0A, contiguous over 160 cycles, then IDLE.
3. HEX_MODE=1. Send 0x00, then 0xFF.
   -> "00\r\n" then "FF\r\n"; second start bit begins 161 cycles after the first.
4. Hold data_valid=1 with 0x11 during a frame, then change to 0x22 before data_ready rises.
   -> only the value present at the data_ready=1 edge (0x22) is transmitted next; nothing is captured while busy.
5. Drop ena for 7 cycles during DATA bit 3 (CLKS_PER_BIT=4, raw 0x0F).
   -> tx level frozen; frame completes 7 cycles late (47 cycles total); decoded byte is still 0x0F.
6. Assert rst_n=0 during DATA bit 5.
   -> tx=1 and data_ready=1 immediately; after release, a new byte 0x5A transmits cleanly with correct framing.

Source files
------------

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - 8N1 UART transmitter for counter bytes, sent raw or as ASCII hex + CR LF
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit HEX_MODE     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]      LAST_CHAR = HEX_MODE ? 2'd3 : 2'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    next_bit;
  logic [1:0]    char_idx;
  logic [7:0]    hold;
  logic [7:0]    cur_char;
  logic          tx_q;
  logic          baud_wrap;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character currently on the wire: the held byte itself, or one of hi/lo/CR/LF.
  always_comb begin
    cur_char = hold;
    if (HEX_MODE) begin
      case (char_idx)
        2'd0:    cur_char = hex_ascii(hold[7:4]);
        2'd1:    cur_char = hex_ascii(hold[3:0]);
        2'd2:    cur_char = 8'h0D;
        default: cur_char = 8'h0A;
      endcase
    end
  end

  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign next_bit   = bit_idx + 3'd1;
  assign data_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      char_idx <= 2'd0;
      hold     <= 8'h00;
      tx_q     <= 1'b1;
    end else if (ena) begin
      if (state != S_IDLE) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (data_valid) begin
            hold     <= data_in;
            char_idx <= 2'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            bit_idx <= 3'd0;
            tx_q    <= cur_char[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= next_bit;
              tx_q    <= cur_char[next_bit];
            end
          end
        end
        default: begin
          // Next frame starts straight out of the stop bit, so hex frames are gapless.
          if (baud_wrap) begin
            bit_idx <= 3'd0;
            if (char_idx != LAST_CHAR) begin
              char_idx <= char_idx + 2'd1;
              tx_q     <= 1'b0;
              state    <= S_START;
            end else begin
              tx_q  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed scoreboard bench for count_uart_tx (raw and hex instances)
module tb_count_uart_tx;

  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic       ena_q = 1'b1;
  logic [7:0] din [2];
  logic       dv  [2];
  logic       rdy [2];
  logic       txw [2];
  logic       bsy [2];

  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  logic       dec_act [2];
  int         dec_k   [2];
  logic [9:0] dec_sh  [2];
  int         frames  [2];

  count_uart_tx #(.CLKS_PER_BIT(CPB), .HEX_MODE(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0])
  );

  count_uart_tx #(.CLKS_PER_BIT(CPB), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    logic [7:0] digits [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    return digits[n];
  endfunction

  // Line decoder: a sample following an edge with ena low is a frozen repeat and is skipped.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        dec_act[i] = 1'b0;
      end else if (ena_q) begin
        if (!dec_act[i] && txw[i] === 1'b0) begin
          dec_act[i] = 1'b1;
          dec_k[i]   = 0;
        end
        if (dec_act[i]) begin
          if (dec_k[i] % CPB == CPB / 2) dec_sh[i][dec_k[i] / CPB] = txw[i];
          if (dec_k[i] == 10 * CPB - 1) begin
            dec_act[i] = 1'b0;
            frames[i]++;
            chk(i == 0 ? "raw_framing" : "hex_framing", {dec_sh[i][9], dec_sh[i][0]}, 2'b10);
            if (i == 0) begin
              if (exp_q0.size() == 0) chk("raw_sb_underflow", dec_sh[i][8:1], 8'hxx);
              else chk("raw_byte", dec_sh[i][8:1], exp_q0.pop_front());
            end else begin
              if (exp_q1.size() == 0) chk("hex_sb_underflow", dec_sh[i][8:1], 8'hxx);
              else chk("hex_char", dec_sh[i][8:1], exp_q1.pop_front());
            end
          end
          dec_k[i]++;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge (first start-bit sample).
  task automatic send(input int i, input logic [7:0] b, output int acc_cyc);
    int n;
    din[i] = b;
    dv[i]  = 1'b1;
    n = 0;
    while (!(rdy[i] && ena) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", n, 0);
    @(posedge clk);
    acc_cyc = cyc;
    if (i == 0) begin
      exp_q0.push_back(b);
    end else begin
      exp_q1.push_back(hexc(b[7:4]));
      exp_q1.push_back(hexc(b[3:0]));
      exp_q1.push_back(8'h0D);
      exp_q1.push_back(8'h0A);
    end
    @(negedge clk);
    dv[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bsy[0] || bsy[1]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a1;
    int         a2;
    int         n;
    logic       lvl;
    logic [9:0] fr;

    for (int i = 0; i < 2; i++) begin
      din[i] = 8'h00; dv[i] = 1'b0; dec_act[i] = 1'b0; dec_k[i] = 0; dec_sh[i] = '0; frames[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_tx", txw[i], 1);
      chk("reset_busy", bsy[i], 0);
      chk("reset_ready", rdy[i], 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 1: raw 0xA5, exact waveform
    send(0, 8'hA5, a1);
    fr = {1'b1, 8'hA5, 1'b0};
    n = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("t1_tx_wave", txw[0], fr[k / CPB]);
      if (bsy[0]) n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, 40);
    chk("t1_ready_busy_after", {rdy[0], bsy[0]}, 2'b10);

    // 2: hex 0x3C, four contiguous frames
    send(1, 8'h3C, a1);
    n = 0;
    while (bsy[1] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t2_busy_cycles", n, 160);
    wait_idle();

    // 3: back-to-back hex transactions
    send(1, 8'h00, a1);
    send(1, 8'hFF, a2);
    chk("t3_start_spacing", a2 - a1, 161);
    wait_idle();

    // 4: valid held while busy; only the value at the ready edge is taken
    send(0, 8'h77, a1);
    din[0] = 8'h11;
    dv[0]  = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_ready_low_busy", rdy[0], 0);
    din[0] = 8'h22;
    send(0, 8'h22, a2);
    chk("t4_accept_spacing", a2 - a1, 41);
    wait_idle();

    // 5: ena low for 7 cycles in data bit 3
    send(0, 8'h0F, a1);
    n = 0;
    lvl = 1'b0;
    while (bsy[0] && n < 1000) begin
      if (n == 17) begin
        lvl = txw[0];
        ena = 1'b0;
      end
      if (n > 17 && n <= 24) chk("t5_tx_frozen", txw[0], lvl);
      if (n == 24) ena = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("t5_bit3_level", lvl, 1);
    chk("t5_busy_cycles", n, 47);
    wait_idle();

    // 6: reset during data bit 5, then a clean frame
    send(0, 8'h96, a1);
    repeat (26) @(negedge clk);
    chk("t6_bit5_before_reset", txw[0], 0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_tx", txw[0], 1);
    chk("t6_reset_ready", rdy[0], 1);
    chk("t6_reset_busy", bsy[0], 0);
    exp_q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h5A, a1);
    wait_idle();
    repeat (2) @(negedge clk);

    chk("raw_sb_drained", exp_q0.size(), 0);
    chk("hex_sb_drained", exp_q1.size(), 0);
    chk("raw_frame_count", frames[0], 5);
    chk("hex_frame_count", frames[1], 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
